// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and default width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : serial_adder_pkg

// File: rtl/halfadd.sv
// Half-adder cell: one-bit sum and carry of two inputs.
module halfadd (
  output logic sum,
  output logic c_out,
  input  logic a,
  input  logic b
);

  assign sum   = a ^ b;
  assign c_out = a & b;

endmodule : halfadd

// File: rtl/serial_adder.sv
// Bit-serial adder: captures two WIDTH-bit operands plus carry-in, adds one bit
// per cycle LSB first, then presents sum/c_out with a valid/ready handshake.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_r;
  state_e           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] res_r;
  logic             carry_r;
  logic             accept_s;

  // Full-add of the current operand LSBs and the running carry
  logic             ha0_sum_s;
  logic             ha0_c_s;
  logic             fa_sum_s;
  logic             ha1_c_s;
  logic             fa_c_s;

  halfadd u_ha0 (
    .sum   (ha0_sum_s),
    .c_out (ha0_c_s),
    .a     (a_sh_r[0]),
    .b     (b_sh_r[0])
  );

  halfadd u_ha1 (
    .sum   (fa_sum_s),
    .c_out (ha1_c_s),
    .a     (ha0_sum_s),
    .b     (carry_r)
  );

  assign fa_c_s = ha0_c_s | ha1_c_s;

  // Status outputs decode the registered state only, so in_ready never
  // combinationally follows out_ready.
  assign in_ready  = (state_r == IDLE);
  assign busy      = (state_r == RUN);
  assign out_valid = (state_r == DONE);
  assign sum       = res_r;
  assign c_out     = carry_r;
  assign accept_s  = in_valid && in_ready;

  // Next-state logic: accept in IDLE, WIDTH bit steps in RUN, hold DONE until taken
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == CNT_LAST) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register with reset overriding any same-cycle handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath: load operands on accept, shift one bit per RUN cycle, hold otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= {CNT_W{1'b0}};
      a_sh_r  <= {WIDTH{1'b0}};
      b_sh_r  <= {WIDTH{1'b0}};
      res_r   <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
    end else if (accept_s) begin
      cnt_r   <= {CNT_W{1'b0}};
      a_sh_r  <= a;
      b_sh_r  <= b;
      res_r   <= {WIDTH{1'b0}};
      carry_r <= c_in;
    end else if (state_r == RUN) begin
      cnt_r   <= cnt_r + CNT_W'(1);
      a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
      b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
      res_r   <= {fa_sum_s, res_r[WIDTH-1:1]};
      carry_r <= fa_c_s;
    end else begin
      cnt_r   <= cnt_r;
      a_sh_r  <= a_sh_r;
      b_sh_r  <= b_sh_r;
      res_r   <= res_r;
      carry_r <= carry_r;
    end
  end

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=8.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         busy;

  int n_cmp;
  int n_err;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .busy      (busy)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one cycle once in_ready is high, then wait for out_valid.
  // lat counts the accept cycle as 1; the cycle out_valid is first seen is WIDTH+1.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                          input string tag);
    int guard;
    guard = 0;
    while (!in_ready && guard < 40) begin
      tick();
      guard++;
    end
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    a = ta;
    b = tb;
    c_in = tc;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = 8'h00;
    b = 8'h00;
    c_in = 1'b0;
  endtask

  task automatic finish_op(input logic [W-1:0] es, input logic ec, input string tag);
    int lat;
    lat = 1;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    while (!out_valid && lat < 60) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(W + 1));
    check({tag, "_sum"}, 32'(sum), 32'(es));
    check({tag, "_cout"}, 32'(c_out), 32'(ec));
    check({tag, "_inrdy_done"}, 32'(in_ready), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    a = 8'h00;
    b = 8'h00;
    c_in = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(c_out), 32'd0);

    // Basic additions with out_ready held high
    start_op(8'h00, 8'h00, 1'b0, "zero");
    finish_op(8'h00, 1'b0, "zero");
    tick();
    check("zero_back_idle", 32'(in_ready), 32'd1);
    check("zero_ov_low", 32'(out_valid), 32'd0);

    start_op(8'hFF, 8'h01, 1'b0, "ovf");
    finish_op(8'h00, 1'b1, "ovf");
    tick();
    start_op(8'hA5, 8'h5A, 1'b1, "a55a");
    finish_op(8'h00, 1'b1, "a55a");
    tick();
    start_op(8'h3C, 8'h0F, 1'b0, "3c0f");
    finish_op(8'h4B, 1'b0, "3c0f");
    tick();

    // Backpressure: hold DONE for 20 cycles, ignore new operands meanwhile
    out_ready = 1'b0;
    start_op(8'h80, 8'h80, 1'b1, "bp");
    finish_op(8'h01, 1'b1, "bp");
    a = 8'hFF;
    b = 8'hFF;
    c_in = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp_hold_ov", 32'(out_valid), 32'd1);
      check("bp_hold_sum", 32'(sum), 32'h01);
    end
    check("bp_hold_cout", 32'(c_out), 32'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_inrdy", 32'(in_ready), 32'd1);
    check("bp_release_ov", 32'(out_valid), 32'd0);
    check("bp_release_busy", 32'(busy), 32'd0);
    check("bp_result_kept", 32'(sum), 32'h01);

    // Reset on the 4th RUN cycle abandons the operation
    start_op(8'h55, 8'h22, 1'b0, "rstrun");
    tick();
    tick();
    tick();
    check("rstrun_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstrun_inrdy", 32'(in_ready), 32'd1);
    check("rstrun_ov", 32'(out_valid), 32'd0);
    check("rstrun_sum", 32'(sum), 32'd0);
    check("rstrun_cout", 32'(c_out), 32'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      check("rstrun_no_ov", 32'(out_valid), 32'd0);
    end
    start_op(8'h12, 8'h34, 1'b0, "after_rst");
    finish_op(8'h46, 1'b0, "after_rst");
    tick();

    // Reset wins over a same-cycle accept
    a = 8'h77;
    b = 8'h11;
    in_valid = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    check("rst_vs_accept_busy", 32'(busy), 32'd0);
    check("rst_vs_accept_inrdy", 32'(in_ready), 32'd1);

    // Reset in DONE drops the pending result
    out_ready = 1'b0;
    start_op(8'h01, 8'h01, 1'b0, "rstdone");
    finish_op(8'h02, 1'b0, "rstdone");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    check("rstdone_ov", 32'(out_valid), 32'd0);
    check("rstdone_sum", 32'(sum), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_serial_adder
